// File: rtl/color_sensor_meas.sv
// Colour-sensor front end: measures the R/B/C/G period counts and classifies them against a window table.
// Optional watchdog on stalled sensors is enabled by defining COLOR_TIMEOUT_EN.
module color_sensor_meas #(
    parameter int          CNT_W       = 20,
    parameter int          PERIODS     = 4,
    parameter int          SETTLE      = 64,
    parameter int          NUM_CLASSES = 8,
    parameter int          CLS_W       = 4,
    parameter logic [1:0]  SCALE       = 2'b01,
    parameter bit          CONTINUOUS  = 1'b0,
    parameter int          TIMEOUT_CYC = (1 << 20) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor,
    input  logic             start,
    output logic [1:0]       filt_sel,
    output logic [1:0]       scale,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_r,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_g,
    output logic             meas_valid,
    output logic             cls_hit,
    output logic [CLS_W-1:0] cls_id,
    output logic             timeout,
    input  logic             tbl_we,
    input  logic [CLS_W-1:0] tbl_cls,
    input  logic [1:0]       tbl_ch,
    input  logic [CNT_W-1:0] tbl_lo,
    input  logic [CNT_W-1:0] tbl_hi
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_ARM, S_COUNT, S_NEXT, S_CLASSIFY, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [2:0]       sync_q, sync_d;
    logic [1:0]       ch_q, ch_d;
    logic [1:0]       filt_q, filt_d;
    logic [31:0]      settle_q, settle_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] per_inc;
    logic [7:0]       edges_q, edges_d;
    logic             busy_q, busy_d;
    logic             mv_q, mv_d;
    logic             again_q, again_d;
    logic [CLS_W-1:0] k_q, k_d;
    logic             found_q, found_d;
    logic [CLS_W-1:0] fid_q, fid_d;
    logic             hit_q, hit_d;
    logic [CLS_W-1:0] id_q, id_d;
    logic [CNT_W-1:0] slot_q [4];
    logic [CNT_W-1:0] slot_d [4];
    logic [CNT_W-1:0] out_q [4];
    logic [CNT_W-1:0] out_d [4];
    logic [CNT_W-1:0] lo_q [NUM_CLASSES][4];
    logic [CNT_W-1:0] lo_d [NUM_CLASSES][4];
    logic [CNT_W-1:0] hi_q [NUM_CLASSES][4];
    logic [CNT_W-1:0] hi_d [NUM_CLASSES][4];
    logic             sens_edge;
    logic             match;

`ifdef COLOR_TIMEOUT_EN
    logic [31:0]      wdog_q, wdog_d;
    logic             timeout_q, timeout_d;
`endif

    // sync_q[1] is the second synchroniser flop, sync_q[2] its delayed copy
    assign sens_edge = sync_q[1] & ~sync_q[2];
    assign per_inc   = (per_q == CNT_MAX) ? per_q : per_q + 1'b1;

    // Window compare for the class currently addressed by k_q
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (k_q == CLS_W'(i)) begin
                match = 1'b1;
                for (int c = 0; c < 4; c++) begin
                    if (!(lo_q[i][c] < slot_q[c] && slot_q[c] < hi_q[i][c]))
                        match = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sync_d   = {sync_q[1:0], sensor};
        ch_d     = ch_q;
        filt_d   = filt_q;
        settle_d = settle_q;
        per_d    = per_q;
        edges_d  = edges_q;
        busy_d   = busy_q;
        mv_d     = 1'b0;
        again_d  = again_q;
        k_d      = k_q;
        found_d  = found_q;
        fid_d    = fid_q;
        hit_d    = hit_q;
        id_d     = id_q;
        slot_d   = slot_q;
        out_d    = out_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
`ifdef COLOR_TIMEOUT_EN
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start || (CONTINUOUS && again_q)) begin
                    state_d  = S_SETTLE;
                    ch_d     = 2'd0;
                    filt_d   = 2'd0;
                    settle_d = '0;
                    busy_d   = 1'b1;
                    again_d  = 1'b0;
`ifdef COLOR_TIMEOUT_EN
                    if (start)
                        timeout_d = 1'b0;
`endif
                end
            end
            S_SETTLE: begin
                if (settle_q + 32'd1 >= 32'(SETTLE)) begin
                    state_d = S_ARM;
`ifdef COLOR_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end else begin
                    settle_d = settle_q + 32'd1;
                end
            end
            S_ARM: begin
                if (sens_edge) begin
                    per_d   = '0;
                    edges_d = '0;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                // The closing edge cycle belongs to the span, hence per_inc
                per_d = per_inc;
                if (sens_edge) begin
                    edges_d = edges_q + 8'd1;
                    if (edges_q + 8'd1 == 8'(PERIODS)) begin
                        slot_d[ch_q] = per_inc;
                        state_d      = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (ch_q == 2'd3) begin
                    state_d = S_CLASSIFY;
                    k_d     = '0;
                    found_d = 1'b0;
                    fid_d   = '0;
                end else begin
                    ch_d     = ch_q + 2'd1;
                    filt_d   = ch_q + 2'd1;
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end
            end
            S_CLASSIFY: begin
                if (match && !found_q) begin
                    found_d = 1'b1;
                    fid_d   = k_q;
                end
                if (k_q == CLS_W'(NUM_CLASSES - 1)) begin
                    state_d = S_DONE;
                    out_d   = slot_q;
                    hit_d   = found_q | match;
                    id_d    = found_q ? fid_q : (match ? k_q : '0);
                    mv_d    = 1'b1;
                    busy_d  = 1'b0;
                    again_d = CONTINUOUS;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef COLOR_TIMEOUT_EN
        if (state_q == S_ARM || state_q == S_COUNT) begin
            wdog_d = sens_edge ? '0 : wdog_q + 32'd1;
            if (!sens_edge && wdog_q + 32'd1 >= 32'(TIMEOUT_CYC)) begin
                slot_d[ch_q] = CNT_MAX;
                timeout_d    = 1'b1;
                state_d      = S_NEXT;
            end
        end
`endif

        if (tbl_we && state_q != S_CLASSIFY) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (tbl_cls == CLS_W'(i)) begin
                    lo_d[i][tbl_ch] = tbl_lo;
                    hi_d[i][tbl_ch] = tbl_hi;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sync_q   <= '0;
            ch_q     <= '0;
            filt_q   <= '0;
            settle_q <= '0;
            per_q    <= '0;
            edges_q  <= '0;
            busy_q   <= 1'b0;
            mv_q     <= 1'b0;
            again_q  <= 1'b0;
            k_q      <= '0;
            found_q  <= 1'b0;
            fid_q    <= '0;
            hit_q    <= 1'b0;
            id_q     <= '0;
            slot_q   <= '{default: '0};
            out_q    <= '{default: '0};
            lo_q     <= '{default: '{default: '0}};
            hi_q     <= '{default: '{default: '0}};
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            ch_q     <= ch_d;
            filt_q   <= filt_d;
            settle_q <= settle_d;
            per_q    <= per_d;
            edges_q  <= edges_d;
            busy_q   <= busy_d;
            mv_q     <= mv_d;
            again_q  <= again_d;
            k_q      <= k_d;
            found_q  <= found_d;
            fid_q    <= fid_d;
            hit_q    <= hit_d;
            id_q     <= id_d;
            slot_q   <= slot_d;
            out_q    <= out_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
        end
    end

`ifdef COLOR_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign filt_sel   = filt_q;
    assign scale      = SCALE;
    assign busy       = busy_q;
    assign meas_valid = mv_q;
    assign cls_hit    = hit_q;
    assign cls_id     = id_q;
    assign cnt_r      = out_q[0];
    assign cnt_b      = out_q[1];
    assign cnt_c      = out_q[2];
    assign cnt_g      = out_q[3];

endmodule

// File: tb/tb_color_sensor_meas.sv
// Randomised scoreboard bench for color_sensor_meas (default build, no watchdog).
// Sensor periods per filter channel come from the bench; expected results from a plain model.
module tb_color_sensor_meas;

    localparam int CW   = 20;
    localparam int P    = 4;
    localparam int ST   = 64;
    localparam int NC   = 8;
    localparam int CLW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [3:0][CW-1:0] c;
        logic               hit;
        logic [CLW-1:0]     id;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sensor = 1'b0;
    logic           start = 1'b0;
    logic           tbl_we = 1'b0;
    logic [CLW-1:0] tbl_cls = '0;
    logic [1:0]     tbl_ch = '0;
    logic [CW-1:0]  tbl_lo = '0;
    logic [CW-1:0]  tbl_hi = '0;
    logic [1:0]     filt_sel;
    logic [1:0]     scale;
    logic           busy;
    logic [CW-1:0]  cnt_r, cnt_b, cnt_c, cnt_g;
    logic           meas_valid;
    logic           cls_hit;
    logic [CLW-1:0] cls_id;
    logic           timeout;

    color_sensor_meas #(
        .CNT_W(CW), .PERIODS(P), .SETTLE(ST),
        .NUM_CLASSES(NC), .CLS_W(CLW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sensor(sensor), .start(start),
        .filt_sel(filt_sel), .scale(scale), .busy(busy),
        .cnt_r(cnt_r), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_g(cnt_g),
        .meas_valid(meas_valid), .cls_hit(cls_hit), .cls_id(cls_id),
        .timeout(timeout), .tbl_we(tbl_we), .tbl_cls(tbl_cls),
        .tbl_ch(tbl_ch), .tbl_lo(tbl_lo), .tbl_hi(tbl_hi)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   per [4] = '{100, 100, 100, 100};
    int   mlo [NC][4];
    int   mhi [NC][4];
    int   phase = 0;
    bit   hold_low = 1'b0;
    bit   log_en = 1'b0;
    bit   prev_mv = 1'b0;
    exp_t sb [$];
    int   fseq [$];

    task automatic chk(input string n, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", n, act, exp);
        end
    endtask

    // Sensor: rising edge exactly every per[channel] clocks
    always @(negedge clk) begin
        if (hold_low) begin
            sensor = 1'b0;
        end else begin
            phase = phase + 1;
            if (phase >= per[filt_sel]) phase = 0;
            sensor = (phase < per[filt_sel] / 2);
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (log_en && (fseq.size() == 0 || fseq[$] != int'(filt_sel)))
            fseq.push_back(int'(filt_sel));
        if (rst_n && meas_valid) begin
            chk("busy_low_at_valid", busy, 0);
            if (prev_mv) chk("valid_single_pulse", 1, 0);
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("cnt_r", cnt_r, e.c[0]);
                chk("cnt_b", cnt_b, e.c[1]);
                chk("cnt_c", cnt_c, e.c[2]);
                chk("cnt_g", cnt_g, e.c[3]);
                chk("cls_hit", cls_hit, e.hit);
                chk("cls_id", cls_id, e.id);
            end
        end
        prev_mv = meas_valid;
    end

    function automatic exp_t model();
        exp_t e;
        int   v [4];
        bit   m;
        e = '0;
        for (int c = 0; c < 4; c++) begin
            v[c] = P * per[c];
            if (v[c] > CMAX) v[c] = CMAX;
            e.c[c] = CW'(v[c]);
        end
        for (int k = 0; k < NC; k++) begin
            if (!e.hit) begin
                m = 1'b1;
                for (int c = 0; c < 4; c++)
                    if (!(mlo[k][c] < v[c] && v[c] < mhi[k][c])) m = 1'b0;
                if (m) begin
                    e.hit = 1'b1;
                    e.id  = CLW'(k);
                end
            end
        end
        return e;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < NC; k++)
            for (int c = 0; c < 4; c++) begin
                mlo[k][c] = 0;
                mhi[k][c] = 0;
            end
    endtask

    task automatic twr(input int cls, input int ch, input int lo, input int hi);
        tbl_we  = 1'b1;
        tbl_cls = CLW'(cls);
        tbl_ch  = 2'(ch);
        tbl_lo  = CW'(lo);
        tbl_hi  = CW'(hi);
        @(negedge clk);
        tbl_we = 1'b0;
        if (cls < NC) begin
            mlo[cls][ch] = lo;
            mhi[cls][ch] = hi;
        end
    endtask

    task automatic twr_all(input int cls, input int lo, input int hi);
        for (int c = 0; c < 4; c++) twr(cls, c, lo, hi);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string n);
        int cyc = 0;
        while (sb.size() != 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        if (sb.size() != 0) begin
            chk(n, sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic measure(input string n);
        sb.push_back(model());
        pulse_start();
        chk("busy_after_start", busy, 1);
        wait_drain(n);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_filt(input logic [1:0] f);
        int cyc = 0;
        while (filt_sel != f && cyc < 10000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_filt", filt_sel, f);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        clear_model();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit actual=expired required=finished");
        $fatal(1);
    end

    initial begin
        clear_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_filt_sel", filt_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_cnt_r", cnt_r, 0);
        chk("rst_cnt_g", cnt_g, 0);
        chk("rst_cls_hit", cls_hit, 0);
        chk("rst_cls_id", cls_id, 0);
        chk("rst_timeout", timeout, 0);
        chk("scale", scale, 2'b01);

        // Cleared table, equal periods, filter sequence logged
        log_en = 1'b1;
        measure("t1_drain");
        log_en = 1'b0;
        chk("filt_seq_len", fseq.size(), 4);
        for (int i = 0; i < 4 && i < fseq.size(); i++)
            chk("filt_seq", fseq[i], i);

        // Overlapping windows: lowest index wins
        twr_all(2, 350, 450);
        twr_all(5, 300, 500);
        measure("t2_drain");

        // Out-of-range class index and strict bounds
        twr_all(9, 0, 100000);
        twr_all(0, 400, 500);
        measure("t3a_drain");
        twr_all(0, 399, 500);
        measure("t3b_drain");

        for (int it = 0; it < 8; it++) begin
            int v [4];
            for (int c = 0; c < 4; c++) begin
                per[c] = $urandom_range(20, 120);
                v[c]   = P * per[c];
            end
            for (int w = 0; w < 3; w++) begin
                int cls  = $urandom_range(0, 9);
                int mode = $urandom_range(0, 2);
                for (int c = 0; c < 4; c++) begin
                    int lo, hi;
                    if (mode == 0) begin
                        lo = v[c] - $urandom_range(1, 40);
                        hi = v[c] + $urandom_range(1, 40);
                    end else if (mode == 1) begin
                        lo = v[c];
                        hi = v[c] + 10;
                    end else begin
                        lo = $urandom_range(0, 600);
                        hi = lo + $urandom_range(0, 100);
                    end
                    twr(cls, c, lo, hi);
                end
            end
            measure("rand_drain");
        end

        // Start while busy and start during the DONE cycle are ignored
        for (int c = 0; c < 4; c++) per[c] = 100;
        sb.push_back(model());
        pulse_start();
        repeat (500) @(negedge clk);
        pulse_start();
        begin
            int cyc = 0;
            while (!meas_valid && cyc < 20000) begin
                @(negedge clk);
                cyc++;
            end
            chk("t4_valid_seen", meas_valid, 1);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        chk("t4_busy_idle", busy, 0);
        chk("t4_sb_empty", sb.size(), 0);

        // Reset in the middle of channel C counting
        sb.push_back(model());
        pulse_start();
        wait_filt(2'b10);
        repeat (ST + 200) @(negedge clk);
        chk("t5_busy_before", busy, 1);
        do_reset();
        chk("t5_filt_sel", filt_sel, 0);
        chk("t5_busy", busy, 0);
        chk("t5_valid", meas_valid, 0);
        chk("t5_cnt_r", cnt_r, 0);
        chk("t5_cnt_b", cnt_b, 0);
        chk("t5_cnt_c", cnt_c, 0);
        chk("t5_cnt_g", cnt_g, 0);
        chk("t5_cls_hit", cls_hit, 0);
        repeat (3000) @(negedge clk);
        chk("t5_still_idle", busy, 0);

        // Table cleared by reset: window-free measurement gives no hit
        measure("t5b_drain");

        // Stalled sensor on G: block waits in ARM/COUNT
        sb.push_back(model());
        pulse_start();
        wait_filt(2'b11);
        hold_low = 1'b1;
        repeat (3000) @(negedge clk);
        chk("t6_busy_stuck", busy, 1);
        chk("t6_no_valid", sb.size(), 1);
        chk("t6_timeout", timeout, 0);
        do_reset();
        hold_low = 1'b0;
        chk("t6_busy_after_rst", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
